// File: rtl/usbfs_in_aggregator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : usbfs_in_aggregator                                            |
// | Brief   : Byte FIFO feeding the EP 0x81 IN port; it holds bytes back     |
// |           until a fill threshold or an idle timeout, so the core sends   |
// |           fewer, larger IN packets. Optional flush input is enabled by   |
// |           defining USBFS_AGG_FLUSH_EN.                                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module usbfs_in_aggregator #(
  parameter int DEPTH_LOG2     = 6,
  parameter int THRESH         = 32,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic                  rstn,
  input  logic                  clk,
`ifdef USBFS_AGG_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_THR  = (DEPTH_LOG2 + 1)'(THRESH);
  localparam logic [DEPTH_LOG2:0] LVL_ZERO = '0;
  localparam logic [TW-1:0]       TMO_MAX  = TW'(TIMEOUT_CYCLES);

  localparam logic [0:0] ST_HOLD  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic [DEPTH_LOG2:0]   level_d;
  logic [TW-1:0]         timer_q;
  logic [TW-1:0]         timer_d;
  logic [0:0]            state_q;
  logic [0:0]            state_d;

  logic push;
  logic pop;
  logic flush_req;

  // Handshakes depend only on registered state: no s_valid->m_valid or
  // m_ready->s_ready combinational path.
  assign s_ready = (level_q != LVL_FULL);
  assign m_valid = (state_q == ST_DRAIN) && (level_q != LVL_ZERO);
  assign m_data  = mem_q[rd_ptr_q];
  assign level   = level_q;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

`ifdef USBFS_AGG_FLUSH_EN
  assign flush_req = flush && (level_q != LVL_ZERO);
`else
  assign flush_req = 1'b0;
`endif

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (push || (level_q == LVL_ZERO)) begin
      timer_d = '0;
    end else if (timer_q != TMO_MAX) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: begin
        if ((level_q >= LVL_THR) ||
            ((level_q != LVL_ZERO) && (timer_q == TMO_MAX)) ||
            flush_req) begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        // A push coinciding with the last pop keeps level_d non-zero.
        if (level_d == LVL_ZERO) begin
          state_d = ST_HOLD;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      timer_q  <= '0;
      state_q  <= ST_HOLD;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
      timer_q <= timer_d;
      state_q <= state_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usbfs_in_aggregator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_usbfs_in_aggregator                                         |
// | Brief   : Scoreboard bench for usbfs_in_aggregator (USBFS_AGG_FLUSH_EN   |
// |           adds the flush scenario).                                      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_usbfs_in_aggregator;

  localparam int DL  = 6;
  localparam int TH  = 32;
  localparam int TMO = 100;

  logic          rstn;
  logic          clk;
`ifdef USBFS_AGG_FLUSH_EN
  logic          flush;
`endif
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic [DL:0]   level;

  int         checks = 0;
  int         errors = 0;
  int         popped = 0;
  bit         track_lvl = 1'b0;
  logic [7:0] exp_q[$];

  usbfs_in_aggregator #(
    .DEPTH_LOG2     (DL),
    .THRESH         (TH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .rstn    (rstn),
    .clk     (clk),
`ifdef USBFS_AGG_FLUSH_EN
    .flush   (flush),
`endif
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor: a pop happens on the next edge, so compare the presented byte.
  always @(negedge clk) begin
    if (rstn && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h required no output", m_data);
      end else begin
        chk("pop_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        popped++;
      end
    end
  end

  // Occupancy must equal bytes accepted but not yet delivered.
  always @(posedge clk) begin
    if (track_lvl) begin
      #2;
      chk("level_track", {25'd0, level}, exp_q.size());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wr(input logic [7:0] d);
    int n = 0;
    s_data  = d;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 1000) begin
        chk("wr_accept_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || level != 0) && n < 2000) begin
      step(1);
      n++;
    end
    chk({nm, "_level0"}, {25'd0, level}, 32'd0);
    chk({nm, "_all_out"}, exp_q.size(), 32'd0);
    step(2);
  endtask

  // Edges from the accepting edge (counted as 1) until m_valid is seen.
  task automatic latency(input string nm, input int req);
    int cnt = 1;
    while (!m_valid && cnt < req + 10) begin
      step(1);
      cnt++;
    end
    chk(nm, cnt, req);
  endtask

  initial begin
    int p0;
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b1;
`ifdef USBFS_AGG_FLUSH_EN
    flush   = 1'b0;
`endif
    #12;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_level", {25'd0, level}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step(1);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);

    // 1: threshold release
    p0 = popped;
    for (int i = 0; i < 32; i++) begin
      wr(8'(i));
      if (i == 0 || i == 31) chk("t1_hold_mvalid", {31'd0, m_valid}, 32'd0);
    end
    chk("t1_level32", {25'd0, level}, 32'd32);
    step(1);
    chk("t1_release_mvalid", {31'd0, m_valid}, 32'd1);
    wait_drain("t1");
    chk("t1_count", popped - p0, 32'd32);

    // 2: timeout release of a partial packet
    p0 = popped;
    for (int i = 0; i < 5; i++) wr(8'(8'hA0 + i));
    chk("t2_level5", {25'd0, level}, 32'd5);
    latency("t2_timeout_latency", TMO + 2);
    wait_drain("t2");
    chk("t2_count", popped - p0, 32'd5);

    // 3: fill to full with the core stalled, then release across the wrap
    p0 = popped;
    m_ready   = 1'b0;
    track_lvl = 1'b1;
    fork
      begin
        for (int i = 0; i < 70; i++) wr(8'(8'h40 + i));
      end
      begin
        int n = 0;
        while (level != 64 && n < 500) begin
          step(1);
          n++;
        end
        chk("t3_full_level", {25'd0, level}, 32'd64);
        chk("t3_full_sready", {31'd0, s_ready}, 32'd0);
        step(5);
        chk("t3_full_hold", {25'd0, level}, 32'd64);
        m_ready = 1'b1;
      end
    join
    wait_drain("t3");
    track_lvl = 1'b0;
    chk("t3_count", popped - p0, 32'd70);

    // 4: continuous writes during DRAIN with m_ready toggling
    p0 = popped;
    m_ready = 1'b0;
    for (int i = 0; i < 32; i++) wr(8'(8'h80 + i));
    step(1);
    chk("t4_drain_mvalid", {31'd0, m_valid}, 32'd1);
    track_lvl = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) wr(8'(8'hE0 + i));
      end
      begin
        for (int i = 0; i < 20; i++) begin
          m_ready = (i % 2 == 0);
          step(1);
        end
      end
    join
    m_ready = 1'b1;
    wait_drain("t4");
    track_lvl = 1'b0;
    chk("t4_count", popped - p0, 32'd52);

    // 5: reset in the middle of a drain
    m_ready = 1'b0;
    for (int i = 0; i < 40; i++) wr(8'(8'h30 + i));
    step(1);
    chk("t5_drain_mvalid", {31'd0, m_valid}, 32'd1);
    m_ready = 1'b1;
    step(3);
    #1;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_rst_mvalid", {31'd0, m_valid}, 32'd0);
    chk("t5_rst_level", {25'd0, level}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step(1);
    p0 = popped;
    wr(8'h5A);
    wr(8'h5B);
    wr(8'h5C);
    latency("t5_timeout_latency", TMO + 2);
    wait_drain("t5");
    chk("t5_count", popped - p0, 32'd3);

`ifdef USBFS_AGG_FLUSH_EN
    // 6: flush forces an early release, and is ignored when empty
    p0 = popped;
    wr(8'h11);
    wr(8'h22);
    step(10);
    chk("t6_pre_flush", {31'd0, m_valid}, 32'd0);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("t6_flush_mvalid", {31'd0, m_valid}, 32'd1);
    wait_drain("t6");
    chk("t6_count", popped - p0, 32'd2);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("t6_empty_flush", {31'd0, m_valid}, 32'd0);
    step(1);
    chk("t6_empty_flush2", {31'd0, m_valid}, 32'd0);
`endif

    chk("end_s_ready", {31'd0, s_ready}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
